// File: rtl/fir3_mac_sequencer.sv
// fir3_mac_sequencer
// Time-multiplexed 3-tap FIR controller. One sample is accepted at a time and
// its three tap products are formed in turn on a single external multiplier
// (mul_a * mul_b -> mul_p, combinational), then summed in a local accumulator.
// The block also owns the delay line and the coefficient bank, and hands each
// result downstream on a valid/ready interface.
//
// Timeline for one sample (accept at edge N):
//   N   : IDLE -> TAP0   (cur captured)
//   N+1 : TAP0 -> TAP1   (acc  = cur*c0)
//   N+2 : TAP1 -> TAP2   (acc += d1*c1)
//   N+3 : TAP2 -> OUT    (acc += d2*c2, delay line shifts)
//   OUT holds out_valid until out_ready, then returns to IDLE.

module fir3_mac_sequencer #(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int ACC_W  = DATA_W + COEF_W + 2
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic signed [DATA_W-1:0]        in_data,
   input  logic                            coef_we,
   input  logic        [1:0]               coef_addr,
   input  logic signed [COEF_W-1:0]        coef_wdata,
   input  logic                            flush,
   output logic signed [DATA_W-1:0]        mul_a,
   output logic signed [COEF_W-1:0]        mul_b,
   input  logic signed [DATA_W+COEF_W-1:0] mul_p,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic signed [ACC_W-1:0]         out_data,
   output logic                            busy
);

   localparam int PROD_W = DATA_W + COEF_W;

   typedef enum logic [2:0] {
      IDLE,
      TAP0,
      TAP1,
      TAP2,
      OUT
   } state_t;

   state_t state;
   state_t state_nxt;

   // Current sample and the two previous samples (delay line).
   logic signed [DATA_W-1:0] cur;
   logic signed [DATA_W-1:0] d1;
   logic signed [DATA_W-1:0] d2;

   // Coefficient bank.
   logic signed [COEF_W-1:0] c0;
   logic signed [COEF_W-1:0] c1;
   logic signed [COEF_W-1:0] c2;

   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  prod_ext;

   logic idle;
   logic accept;
   logic coef_wr;

   // Side effects (accept, flush, coefficient write) are only honoured in IDLE.
   assign idle    = (state == IDLE);
   assign accept  = idle & in_valid;
   assign coef_wr = idle & coef_we;

   // Sign-extend the product to accumulator width; ACC_W leaves two guard
   // bits, enough for the sum of three full-scale products.
   assign prod_ext = {{(ACC_W-PROD_W){mul_p[PROD_W-1]}}, mul_p};

   // The accumulator only changes in TAP states, so it is stable in OUT.
   assign out_data = acc;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values,
      // regardless of the order in which always blocks are evaluated.
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and state-decoded outputs.
   always_comb begin
      // NOTE: everything assigned here is given a default first; a path that
      // skipped an assignment would otherwise infer a latch.
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      mul_a     = '0;
      mul_b     = '0;

      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               state_nxt = TAP0;
            end
         end
         TAP0: begin
            mul_a     = cur;
            mul_b     = c0;
            state_nxt = TAP1;
         end
         TAP1: begin
            mul_a     = d1;
            mul_b     = c1;
            state_nxt = TAP2;
         end
         TAP2: begin
            mul_a     = d2;
            mul_b     = c2;
            state_nxt = OUT;
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            // Unreachable encodings recover to IDLE.
            in_ready  = 1'b1;
            busy      = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   // Sample capture and delay-line maintenance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur <= '0;
         d1  <= '0;
         d2  <= '0;
      end else begin
         // Flush only clears history; a sample accepted in the same cycle
         // still loads into cur and sees an empty delay line.
         if (idle && flush) begin
            d1 <= '0;
            d2 <= '0;
         end
         if (accept) begin
            cur <= in_data;
         end
         // Shift after the last tap has consumed d1/d2, so the next sample
         // sees this one as d1.
         if (state == TAP2) begin
            d2 <= d1;
            d1 <= cur;
         end
      end
   end

   // Multiply-accumulate over the three tap states.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else begin
         case (state)
            TAP0:       acc <= prod_ext;
            TAP1, TAP2: acc <= acc + prod_ext;
            default:    acc <= acc;
         endcase
      end
   end

   // Coefficient bank writes; address 3 is a no-op.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the bank is three discrete registers rather than a RAM, so it
      // takes the async reset and the filter output is defined after reset.
      if (!rst_n) begin
         c0 <= '0;
         c1 <= '0;
         c2 <= '0;
      end else if (coef_wr) begin
         case (coef_addr)
            2'd0:    c0 <= coef_wdata;
            2'd1:    c1 <= coef_wdata;
            2'd2:    c2 <= coef_wdata;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fir3_mac_sequencer.sv
// tb_fir3_mac_sequencer
// Scoreboard bench: the driver computes each expected result from a plain
// arithmetic FIR model (y = c0*x[n] + c1*x[n-1] + c2*x[n-2]) and queues it;
// a monitor pops and compares on every out_valid/out_ready handshake. The
// environment supplies the combinational multiplier on mul_a/mul_b/mul_p.

`timescale 1ns/1ps

module tb_fir3_mac_sequencer;

   localparam int DATA_W = 8;
   localparam int COEF_W = 8;
   localparam int ACC_W  = DATA_W + COEF_W + 2;

   logic                            clk = 1'b0;
   logic                            rst_n = 1'b0;
   logic                            in_valid = 1'b0;
   logic                            in_ready;
   logic signed [DATA_W-1:0]        in_data = '0;
   logic                            coef_we = 1'b0;
   logic        [1:0]               coef_addr = '0;
   logic signed [COEF_W-1:0]        coef_wdata = '0;
   logic                            flush = 1'b0;
   logic signed [DATA_W-1:0]        mul_a;
   logic signed [COEF_W-1:0]        mul_b;
   logic signed [DATA_W+COEF_W-1:0] mul_p;
   logic                            out_valid;
   logic                            out_ready = 1'b1;
   logic signed [ACC_W-1:0]         out_data;
   logic                            busy;

   fir3_mac_sequencer #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .coef_we    (coef_we),
      .coef_addr  (coef_addr),
      .coef_wdata (coef_wdata),
      .flush      (flush),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_p      (mul_p),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .busy       (busy)
   );

   // External shared multiplier (signed, combinational).
   assign mul_p = mul_a * mul_b;

   always #5 clk = ~clk;

   longint cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   typedef struct {
      longint data;
      longint acc_cyc;
   } exp_t;

   exp_t sb[$];

   // Reference model state.
   int mc[3];
   int h1;
   int h2;

   bit rand_ready = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mc[0] = 0;
      mc[1] = 0;
      mc[2] = 0;
      h1    = 0;
      h2    = 0;
   endtask

   // Advance one cycle; inputs change 1ns after the rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!in_ready && n < 60) begin
         cyc();
         n++;
      end
      if (!in_ready) check("idle_timeout", in_ready, 1);
   endtask

   task automatic send(input int x, input bit fl, input bit cw, input int ca, input int cv);
      exp_t e;
      wait_idle();
      in_valid   = 1'b1;
      in_data    = x[DATA_W-1:0];
      flush      = fl;
      coef_we    = cw;
      coef_addr  = ca[1:0];
      coef_wdata = cv[COEF_W-1:0];
      if (fl) begin
         h1 = 0;
         h2 = 0;
      end
      if (cw && ca != 3) mc[ca] = cv;
      e.data    = longint'(mc[0] * x + mc[1] * h1 + mc[2] * h2);
      e.acc_cyc = cycle + 1;
      sb.push_back(e);
      h2 = h1;
      h1 = x;
      cyc();
      in_valid = 1'b0;
      flush    = 1'b0;
      coef_we  = 1'b0;
   endtask

   task automatic write_coef(input int ca, input int cv);
      wait_idle();
      coef_we    = 1'b1;
      coef_addr  = ca[1:0];
      coef_wdata = cv[COEF_W-1:0];
      if (ca != 3) mc[ca] = cv;
      cyc();
      coef_we = 1'b0;
   endtask

   task automatic do_flush();
      wait_idle();
      flush = 1'b1;
      h1 = 0;
      h2 = 0;
      cyc();
      flush = 1'b0;
   endtask

   // Monitor: latency, stall stability and result comparison.
   initial begin
      exp_t   e;
      bit     prev_valid = 1'b0;
      bit     stall_prev = 1'b0;
      longint stall_data = 0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (stall_prev) begin
               check("stall_out_valid", out_valid, 1);
               check("stall_out_data", out_data, stall_data);
            end
            if (out_valid && !prev_valid) begin
               if (sb.size() == 0) check("unexpected_out_valid", out_valid, 0);
               else check("latency", cycle - sb[0].acc_cyc, 3);
            end
            if (out_valid && out_ready && sb.size() != 0) begin
               e = sb.pop_front();
               check("out_data", out_data, e.data);
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            prev_valid = out_valid;
         end else begin
            stall_prev = 1'b0;
            prev_valid = 1'b0;
         end
      end
   end

   initial begin
      int n;
      model_reset();

      // Reset state.
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_out_data", out_data, 0);
      check("rst_mul_a", mul_a, 0);
      check("rst_mul_b", mul_b, 0);
      repeat (3) cyc();
      rst_n = 1'b1;
      cyc();

      // Impulse response.
      write_coef(0, 3);
      write_coef(1, -2);
      write_coef(2, 5);
      send(1, 0, 0, 0, 0);
      send(0, 0, 0, 0, 0);
      send(0, 0, 0, 0, 0);
      send(0, 0, 0, 0, 0);

      // Operand muxing and coefficient write gating outside IDLE.
      send(6, 0, 0, 0, 0);
      check("tap0_mul_a", mul_a, 6);
      check("tap0_mul_b", mul_b, 3);
      check("tap0_busy", busy, 1);
      cyc();
      check("tap1_in_ready", in_ready, 0);
      check("tap1_mul_b", mul_b, -2);
      coef_we    = 1'b1;
      coef_addr  = 2'd0;
      coef_wdata = 8'sd7;
      cyc();
      coef_we = 1'b0;
      check("tap2_mul_a", mul_a, 0);
      check("tap2_mul_b", mul_b, 5);
      send(1, 1, 0, 0, 0);
      send(2, 1, 1, 0, 7);

      // Backpressure: result held for 10 cycles, inputs refused meanwhile.
      wait_idle();
      out_ready = 1'b0;
      send(5, 1, 0, 0, 0);
      n = 0;
      while (!out_valid && n < 10) begin
         cyc();
         n++;
      end
      check("bp_out_valid", out_valid, 1);
      in_valid = 1'b1;
      in_data  = 8'sd99;
      for (int i = 0; i < 10; i++) begin
         cyc();
         check("bp_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cyc();
      check("bp_release_in_ready", in_ready, 1);
      check("bp_release_busy", busy, 0);
      check("bp_release_out_valid", out_valid, 0);

      // Full-scale negative operands.
      write_coef(0, -128);
      write_coef(1, -128);
      write_coef(2, -128);
      send(-128, 1, 0, 0, 0);
      send(-128, 0, 0, 0, 0);
      send(-128, 0, 0, 0, 0);

      // Flush between samples.
      write_coef(0, 1);
      write_coef(1, 1);
      write_coef(2, 1);
      send(1, 1, 0, 0, 0);
      send(2, 0, 0, 0, 0);
      do_flush();
      send(3, 0, 0, 0, 0);

      // Reset in the middle of a sequence.
      send(9, 0, 0, 0, 0);
      cyc();
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_busy", busy, 0);
      sb.delete();
      model_reset();
      cyc();
      cyc();
      rst_n = 1'b1;
      cyc();
      send(4, 0, 0, 0, 0);

      // Randomized traffic with random backpressure, writes and flushes.
      rand_ready = 1'b1;
      for (int i = 0; i < 60; i++) begin
         int x;
         int cv;
         x  = int'($urandom_range(0, 255)) - 128;
         cv = int'($urandom_range(0, 255)) - 128;
         if ($urandom_range(0, 9) == 0) do_flush();
         send(x, ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1),
              int'($urandom_range(0, 3)), cv);
      end

      // Drain.
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         cyc();
         n++;
      end
      check("drain_empty", sb.size(), 0);
      repeat (2) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
